// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port vram between display scan-out, cpu and a clear engine.
// Optional feature macro VRAM_XOR_EN: cpu XOR writes become a locked read-modify-write with collision flag.
module vram_arbiter #(
  parameter int HW           = 7,
  parameter int VW           = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [HW-1:0] disp_hpos,
  input  logic [VW-1:0] disp_vpos,
  output logic [1:0]    disp_pixel,
  output logic          disp_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_xor,
  input  logic [HW-1:0] cpu_hpos,
  input  logic [VW-1:0] cpu_vpos,
  input  logic [1:0]    cpu_pixeli,
  output logic [1:0]    cpu_pixelo,
  output logic          cpu_ack,
  output logic          cpu_collision,
  input  logic          clr_start,
  input  logic [1:0]    clr_value,
  output logic          clr_busy,
  output logic [HW-1:0] vram_hpos,
  output logic [VW-1:0] vram_vpos,
  output logic          vram_we,
  output logic [1:0]    vram_pixeli,
  input  logic [1:0]    vram_pixelo
);
  localparam int AW = HW + VW;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

  clr_state_e    clr_state_q, clr_state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [1:0]    clr_val_q, clr_val_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [HW-1:0] hpos_q;
  logic [VW-1:0] vpos_q;
  logic          disp_vld_q, disp_vld_d;
  logic          ack_q, ack_d;
  logic          rd_q, rd_d;

  logic          lock, cpu_rmw, coll;
  logic [1:0]    lock_wdata, old_pix;
  logic          cpu_act, starved;
  logic          g_lock, g_cpu, g_disp, g_clr;

  // The ack cycle masks cpu_req so a still-held request is not taken as a new one.
  assign cpu_act = cpu_req & ~ack_q & ~lock & ~reset;
  assign starved = starve_q == SW'(STARVE_LIMIT);
  assign g_lock  = lock & ~reset;
  assign g_cpu   = cpu_act & (starved | ~disp_req);
  assign g_disp  = disp_req & ~lock & ~reset & ~(cpu_act & starved);
  assign g_clr   = (clr_state_q == CLR_RUN) & ~lock & ~reset & ~disp_req & ~cpu_act;

`ifdef VRAM_XOR_EN
  typedef enum logic {XOR_IDLE, XOR_WR} xor_state_e;

  xor_state_e xor_state_q, xor_state_d;
  logic [1:0] xor_dat_q, xor_dat_d;
  logic [1:0] old_q, old_d;
  logic       coll_q, coll_d;

  assign lock       = xor_state_q == XOR_WR;
  assign cpu_rmw    = cpu_we & cpu_xor;
  assign lock_wdata = vram_pixelo ^ xor_dat_q;
  assign old_pix    = old_q;
  assign coll       = coll_q;

  // XOR write: read in the grant cycle, write back the XOR in the locked cycle, keep the old pixel for the ack.
  always_comb begin
    xor_state_d = (g_cpu & cpu_rmw) ? XOR_WR : XOR_IDLE;
    xor_dat_d   = g_cpu ? cpu_pixeli : xor_dat_q;
    old_d       = g_lock ? vram_pixelo : 2'b00;
    coll_d      = g_lock & |(vram_pixelo & xor_dat_q);
  end

  // XOR phase state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      xor_state_q <= XOR_IDLE;
      xor_dat_q   <= 2'b00;
      old_q       <= 2'b00;
      coll_q      <= 1'b0;
    end else begin
      xor_state_q <= xor_state_d;
      xor_dat_q   <= xor_dat_d;
      old_q       <= old_d;
      coll_q      <= coll_d;
    end
  end
`else
  logic xor_unused;

  assign lock       = 1'b0;
  assign cpu_rmw    = 1'b0;
  assign lock_wdata = 2'b00;
  assign old_pix    = 2'b00;
  assign coll       = 1'b0;
  assign xor_unused = cpu_xor;
`endif

  // vram port mux from the winner; with no winner the address holds its last value.
  always_comb begin
    vram_hpos   = g_cpu ? cpu_hpos : g_disp ? disp_hpos : g_clr ? clr_cnt_q[HW-1:0] : hpos_q;
    vram_vpos   = g_cpu ? cpu_vpos : g_disp ? disp_vpos : g_clr ? clr_cnt_q[AW-1:HW] : vpos_q;
    vram_we     = g_lock | (g_cpu & cpu_we & ~cpu_rmw) | g_clr;
    vram_pixeli = g_lock ? lock_wdata : g_cpu ? cpu_pixeli : g_clr ? clr_val_q : 2'b00;
  end

  // Next state: clear FSM, starve counter and the one-cycle response flags.
  always_comb begin
    clr_state_d = clr_state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_val_d   = clr_val_q;
    if (clr_state_q == CLR_IDLE) begin
      if (clr_start) begin
        clr_state_d = CLR_RUN;
        clr_cnt_d   = '0;
        clr_val_d   = clr_value;
      end
    end else if (g_clr) begin
      clr_cnt_d   = clr_cnt_q + AW'(1);
      clr_state_d = (&clr_cnt_q) ? CLR_IDLE : CLR_RUN;
    end
    starve_d   = (~cpu_req | g_cpu) ? '0 : (cpu_act & g_disp & ~starved) ? starve_q + SW'(1) : starve_q;
    disp_vld_d = g_disp;
    ack_d      = (g_cpu & ~cpu_rmw) | g_lock;
    rd_d       = g_cpu & ~cpu_we;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_state_q <= CLR_IDLE;
      clr_cnt_q   <= '0;
      clr_val_q   <= 2'b00;
      starve_q    <= '0;
      hpos_q      <= '0;
      vpos_q      <= '0;
      disp_vld_q  <= 1'b0;
      ack_q       <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_val_q   <= clr_val_d;
      starve_q    <= starve_d;
      hpos_q      <= vram_hpos;
      vpos_q      <= vram_vpos;
      disp_vld_q  <= disp_vld_d;
      ack_q       <= ack_d;
      rd_q        <= rd_d;
    end
  end

  assign disp_valid    = disp_vld_q & ~reset;
  assign disp_pixel    = disp_valid ? vram_pixelo : 2'b00;
  assign cpu_ack       = ack_q & ~reset;
  assign cpu_pixelo    = cpu_ack ? (rd_q ? vram_pixelo : old_pix) : 2'b00;
  assign cpu_collision = cpu_ack & coll;
  assign clr_busy      = clr_state_q == CLR_RUN;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a registered-read vram model.
module tb_vram_arbiter;
  logic       clk, reset;
  logic       disp_req, cpu_req, cpu_we, cpu_xor, clr_start;
  logic [6:0] disp_hpos, cpu_hpos;
  logic [5:0] disp_vpos, cpu_vpos;
  logic [1:0] cpu_pixeli, clr_value;
  logic [1:0] disp_pixel, cpu_pixelo, vram_pixeli, vram_pixelo;
  logic       disp_valid, cpu_ack, cpu_collision, clr_busy, vram_we;
  logic [6:0] vram_hpos;
  logic [5:0] vram_vpos;

  typedef struct {int cyc; logic [1:0] pix; logic col;} cpu_exp_t;
  typedef struct {int cyc; logic vld; logic [1:0] pix; logic cp;} disp_exp_t;

  cpu_exp_t  cq[$];
  disp_exp_t dq[$];
  cpu_exp_t  ce;
  disp_exp_t de;
  logic [1:0] mem [8192];
  logic [1:0] exp_mem [8192];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  vram_arbiter dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_hpos(disp_hpos), .disp_vpos(disp_vpos),
    .disp_pixel(disp_pixel), .disp_valid(disp_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_xor(cpu_xor),
    .cpu_hpos(cpu_hpos), .cpu_vpos(cpu_vpos), .cpu_pixeli(cpu_pixeli),
    .cpu_pixelo(cpu_pixelo), .cpu_ack(cpu_ack), .cpu_collision(cpu_collision),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
    .vram_hpos(vram_hpos), .vram_vpos(vram_vpos), .vram_we(vram_we),
    .vram_pixeli(vram_pixeli), .vram_pixelo(vram_pixelo)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (vram_we) mem[{vram_vpos, vram_hpos}] <= vram_pixeli;
    vram_pixelo <= mem[{vram_vpos, vram_hpos}];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (cq.size() > 0 && cq[0].cyc == cyc) begin
      ce = cq.pop_front();
      chk("cpu_ack", cpu_ack, 1);
      chk("cpu_pixelo", cpu_pixelo, ce.pix);
      chk("cpu_collision", cpu_collision, ce.col);
    end else if (cpu_ack) chk("cpu_ack_spurious", cpu_ack, 0);
    if (dq.size() > 0 && dq[0].cyc == cyc) begin
      de = dq.pop_front();
      chk("disp_valid", disp_valid, de.vld);
      if (de.vld && de.cp) chk("disp_pixel", disp_pixel, de.pix);
    end else if (disp_valid) chk("disp_valid_spurious", disp_valid, 0);
  end

  task automatic cpu_op(input logic we, input logic xr, input logic [6:0] h, input logic [5:0] v,
                        input logic [1:0] d);
    int lat;
    logic [1:0] old, ep;
    logic ec, got;
    old = exp_mem[{v, h}];
`ifdef VRAM_XOR_EN
    lat = (we && xr) ? 2 : 1;
`else
    lat = 1;
`endif
    ep = (!we || lat == 2) ? old : 2'b00;
    ec = (lat == 2) && |(old & d);
    cpu_req = 1; cpu_we = we; cpu_xor = xr; cpu_hpos = h; cpu_vpos = v; cpu_pixeli = d;
    cq.push_back('{cyc + lat, ep, ec});
    @(negedge clk);
    chk("grant_we", vram_we, we && lat == 1);
    chk("grant_hpos", vram_hpos, h);
    chk("grant_vpos", vram_vpos, v);
    if (we && lat == 1) chk("grant_wdata", vram_pixeli, d);
    if (lat == 2) begin
      @(negedge clk);
      chk("xor_we", vram_we, 1);
      chk("xor_wdata", vram_pixeli, old ^ d);
      chk("xor_hpos", vram_hpos, h);
    end
    if (we) exp_mem[{v, h}] = (lat == 2) ? old ^ d : d;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      step();
      got = cpu_ack;
    end
    chk("cpu_ack_seen", got, 1);
    step();
    cpu_req = 0; cpu_we = 0; cpu_xor = 0;
  endtask

  task automatic run_clear(input string tag, input logic [1:0] val, input int exp_len, input bit alt_disp,
                           input bit restart_mid);
    int n, w;
    clr_start = 1; clr_value = val;
    step();
    clr_start = 0;
    n = 0; w = 0;
    for (int k = 0; k < 20000; k++) begin
      if (!clr_busy) break;
      n++;
      clr_start = restart_mid && n == 50;
      clr_value = (restart_mid && n == 50) ? ~val : val;
      disp_req = alt_disp && n[0];
      disp_hpos = 0; disp_vpos = 0;
      if (disp_req) dq.push_back('{cyc + 1, 1'b1, 2'b00, 1'b0});
      @(negedge clk);
      if (vram_we) w++;
      if (disp_req) chk({tag, "_disp_we"}, vram_we, 0);
      step();
    end
    clr_start = 0; disp_req = 0;
    chk({tag, "_busy_len"}, n, exp_len);
    chk({tag, "_writes"}, w, 8192);
    for (int i = 0; i < 8192; i++) exp_mem[i] = val;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w;
    for (int i = 0; i < 8192; i++) begin mem[i] = 0; exp_mem[i] = 0; end
    reset = 1; disp_req = 0; cpu_req = 0; cpu_we = 0; cpu_xor = 0; clr_start = 0;
    disp_hpos = 0; disp_vpos = 0; cpu_hpos = 0; cpu_vpos = 0; cpu_pixeli = 0; clr_value = 0;
    repeat (3) step();
    reset = 0;
    step();
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_cpu_pixelo", cpu_pixelo, 0);
    chk("rst_collision", cpu_collision, 0);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_vram_addr", {vram_vpos, vram_hpos}, 0);

    cpu_op(1, 0, 3, 2, 2'b10);
    cpu_op(0, 0, 3, 2, 2'b00);

    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      disp_req = 1; disp_hpos = 3; disp_vpos = 2;
      cpu_req = (i < 6); cpu_we = 0; cpu_hpos = 10; cpu_vpos = 10;
      dq.push_back('{cyc + 1, i != 4, exp_mem[{6'd2, 7'd3}], 1'b1});
      if (i == 4) cq.push_back('{cyc + 1, exp_mem[{6'd10, 7'd10}], 1'b0});
      @(negedge clk);
      chk("starve_hpos", vram_hpos, (i == 4) ? 10 : 3);
    end
    step();
    disp_req = 0; cpu_req = 0;
    step();

    run_clear("clr1", 2'b01, 8192, 0, 1);
    cpu_op(0, 0, 127, 63, 2'b00);
    cpu_op(0, 0, 3, 2, 2'b00);

    run_clear("clr2", 2'b10, 16384, 1, 0);
    cpu_op(0, 0, 64, 32, 2'b00);

    clr_start = 1; clr_value = 2'b01;
    step();
    clr_start = 0;
    w = 0;
    for (int k = 0; k < 1000 && w < 100; k++) begin
      @(negedge clk);
      if (vram_we) w++;
      step();
    end
    chk("abort_count", w, 100);
    reset = 1;
    @(negedge clk);
    chk("abort_rst_we", vram_we, 0);
    step();
    reset = 0;
    chk("abort_busy", clr_busy, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_idle_we", vram_we, 0);
      step();
    end
    for (int i = 0; i < 100; i++) exp_mem[i] = 2'b01;
    cpu_op(0, 0, 99, 0, 2'b00);
    cpu_op(0, 0, 100, 0, 2'b00);
    clr_start = 1; clr_value = 2'b11;
    @(negedge clk);
    chk("restart_start_we", vram_we, 0);
    step();
    clr_start = 0;
    @(negedge clk);
    chk("restart_we", vram_we, 1);
    chk("restart_addr", {vram_vpos, vram_hpos}, 0);
    chk("restart_wdata", vram_pixeli, 2'b11);
    for (int k = 0; k < 10000 && clr_busy; k++) step();
    chk("restart_done", clr_busy, 0);
    for (int i = 0; i < 8192; i++) exp_mem[i] = 2'b11;
    cpu_op(0, 0, 0, 0, 2'b00);

    cpu_op(1, 0, 20, 20, 2'b01);
`ifdef VRAM_XOR_EN
    cpu_op(1, 1, 20, 20, 2'b01);
    cpu_op(0, 0, 20, 20, 2'b00);
    cpu_op(1, 1, 20, 20, 2'b10);
    cpu_op(0, 0, 20, 20, 2'b00);
`else
    cpu_op(1, 1, 20, 20, 2'b10);
    cpu_op(0, 0, 20, 20, 2'b00);
`endif

    repeat (4) step();
    chk("cpu_queue_drained", cq.size(), 0);
    chk("disp_queue_drained", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
